// File: rtl/crc_ctrl_pkg.sv
// Shared definitions for the CRC-3 shift controller: state encoding,
// polynomial constants and the single-step remainder update.
package crc_ctrl_pkg;

  localparam int unsigned CRC_W   = 3;
  localparam int unsigned STATE_W = 2;

  // Low-order taps of x^3+x+1; the x^3 term is implied by the feedback.
  localparam logic [CRC_W-1:0] POLY = 3'b011;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

  // One MSB-first shift step of msg*x^3 mod g (no augmentation bits needed).
  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] r,
                                                input logic             din);
    logic fb;
    fb = din ^ r[CRC_W-1];
    return {r[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & POLY);
  endfunction

endpackage

// File: rtl/crc3_shift_reg.sv
// Three-flop feedback shift register for CRC-3, with synchronous clear
// (priority over shifting) and a shift enable.
module crc3_shift_reg
  import crc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] r
);

  // Remainder register: clear at word start, advance one bit per enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (en) begin
      r <= crc_next(r, din);
    end
  end

endmodule

// File: rtl/crc_shift_ctrl.sv
// Sequencing controller for the CRC-3 shift register: accepts a word over
// valid/ready, feeds it MSB-first into crc3_shift_reg, and holds the
// remainder under a valid/ready handshake.
// Optional feature macro: CRC_CHECK_EN (compare remainder against in_crc).
module crc_shift_ctrl
  import crc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CRC_W-1:0]  in_crc,
  input  logic              in_check,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_err,
  output logic              busy,
  output logic              ser_bit
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               sr_clr;
  logic               sr_en;
  logic               data_bit;
  logic [CRC_W-1:0]   remainder;

`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0]   exp_crc_q, exp_crc_d;
  logic               check_q, check_d;
`else
  // Generate-only build: check inputs are kept on the port list but unused.
  logic               unused_check_inputs;
  assign unused_check_inputs = ^{in_crc, in_check};
`endif

  // State, counter and latched word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
`ifdef CRC_CHECK_EN
      exp_crc_q <= '0;
      check_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
`ifdef CRC_CHECK_EN
      exp_crc_q <= exp_crc_d;
      check_q   <= check_d;
`endif
    end
  end

  // Next-state, counter and latch-enable logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    sr_clr    = 1'b0;
    sr_en     = 1'b0;
`ifdef CRC_CHECK_EN
    exp_crc_d = exp_crc_q;
    check_d   = check_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          cnt_d     = '0;
          sr_clr    = 1'b1;
          state_d   = ST_SHIFT;
`ifdef CRC_CHECK_EN
          exp_crc_d = in_crc;
          check_d   = in_check;
`endif
        end
      end
      ST_SHIFT: begin
        sr_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Select the current message bit, MSB first.
  if (DATA_W == 1) begin : g_single
    assign data_bit = data_q[0];
  end else begin : g_multi
    logic [CNT_W-1:0] bit_idx;
    assign bit_idx  = CNT_LAST - cnt_q;
    assign data_bit = data_q[bit_idx];
  end

  crc3_shift_reg u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sr_clr),
    .en    (sr_en),
    .din   (data_bit),
    .r     (remainder)
  );

  // Handshake and status decodes of the registered state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    ser_bit   = (state_q == ST_SHIFT) ? data_bit : 1'b0;
    crc_out   = (state_q == ST_DONE) ? remainder : '0;
`ifdef CRC_CHECK_EN
    crc_err   = (state_q == ST_DONE) && check_q && (remainder != exp_crc_q);
`else
    crc_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_crc_shift_ctrl.sv
// Directed testbench for crc_shift_ctrl (DATA_W=8 and DATA_W=1 instances).
module tb_crc_shift_ctrl;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, in_check, out_valid, out_ready, crc_err, busy, ser_bit;
  logic [7:0] in_data;
  logic [2:0] in_crc, crc_out;

  logic       w1_in_valid, w1_in_ready, w1_in_check, w1_out_valid, w1_out_ready;
  logic       w1_crc_err, w1_busy, w1_ser_bit;
  logic [0:0] w1_in_data;
  logic [2:0] w1_in_crc, w1_crc_out;

  int errors = 0;
  int checks = 0;

`ifdef CRC_CHECK_EN
  localparam logic EXP_BAD_ERR = 1'b1;
`else
  localparam logic EXP_BAD_ERR = 1'b0;
`endif

  crc_shift_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_crc(in_crc), .in_check(in_check),
    .out_valid(out_valid), .out_ready(out_ready),
    .crc_out(crc_out), .crc_err(crc_err), .busy(busy), .ser_bit(ser_bit)
  );

  crc_shift_ctrl #(.DATA_W(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data),
    .in_crc(w1_in_crc), .in_check(w1_in_check),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready),
    .crc_out(w1_crc_out), .crc_err(w1_crc_err), .busy(w1_busy), .ser_bit(w1_ser_bit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offer one word when ready and wait (bounded) for its result.
  task automatic run_word(input logic [7:0] d, input logic [2:0] c, input logic chk,
                          output logic [2:0] crc, output logic err, output bit ok);
    ok  = 1'b0;
    crc = 3'bx;
    err = 1'bx;
    for (int n = 0; n < 30 && in_ready !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    in_data  = d;
    in_crc   = c;
    in_check = chk;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (out_valid === 1'b1) begin
        crc = crc_out;
        err = crc_err;
        ok  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (crc_out !== 3'b000) begin errors++; $display("FAIL reset_crc_out: got %b want 000", crc_out); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_crc_err: got %b want 0", crc_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ser_bit !== 1'b0) begin errors++; $display("FAIL reset_ser_bit: got %b want 0", ser_bit); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: in_ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_gen_a5();
    logic ser_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    in_data   = 8'hA5;
    in_check  = 1'b0;
    in_crc    = 3'b000;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (ser_bit !== ser_exp[i]) begin errors++; $display("FAIL a5_ser_bit[%0d]: got %b want %b", i, ser_bit, ser_exp[i]); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL a5_shift_status[%0d]: in_ready=%b out_valid=%b busy=%b want 0/0/1", i, in_ready, out_valid, busy);
      end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL a5_out_valid_latency: got %b want 1", out_valid); end
    checks++; if (crc_out !== 3'b101) begin errors++; $display("FAIL a5_crc_out: got %b want 101", crc_out); end
    checks++; if (crc_err !== 1'b0 || in_ready !== 1'b0 || ser_bit !== 1'b0) begin
      errors++; $display("FAIL a5_done_status: crc_err=%b in_ready=%b ser_bit=%b want 0/0/0", crc_err, in_ready, ser_bit);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL a5_return_idle: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_check  = 1'b0;
    in_data   = 8'hFF;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h00;
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b1 || crc_out !== 3'b011) begin
      errors++; $display("FAIL b2b_ff_crc: out_valid=%b crc_out=%b want 1/011", out_valid, crc_out);
    end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept: in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b1 || crc_out !== 3'b000) begin
      errors++; $display("FAIL b2b_00_crc: out_valid=%b crc_out=%b want 1/000", out_valid, crc_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_check_mode();
    logic [2:0] crc;
    logic       err;
    bit         ok;
    out_ready = 1'b1;
    run_word(8'hA5, 3'b101, 1'b1, crc, err, ok);
    checks++; if (!ok || crc !== 3'b101 || err !== 1'b0) begin
      errors++; $display("FAIL check_match: done=%0d crc=%b err=%b want 1/101/0", ok, crc, err);
    end
    run_word(8'hA5, 3'b100, 1'b1, crc, err, ok);
    checks++; if (!ok || crc !== 3'b101 || err !== EXP_BAD_ERR) begin
      errors++; $display("FAIL check_mismatch: done=%0d crc=%b err=%b want 1/101/%b", ok, crc, err, EXP_BAD_ERR);
    end
    run_word(8'hA5, 3'b100, 1'b0, crc, err, ok);
    checks++; if (!ok || err !== 1'b0) begin
      errors++; $display("FAIL generate_ignores_crc: done=%0d err=%b want 1/0", ok, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    bit seen = 1'b0;
    out_ready = 1'b0;
    for (int n = 0; n < 30 && in_ready !== 1'b1; n++) begin @(posedge clk); #1; end
    in_data  = 8'hA5;
    in_crc   = 3'b100;
    in_check = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_reach_done: out_valid=%b want 1 within 30 cycles", out_valid); end
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      in_data  = 8'h3C ^ 8'(k);
      in_crc   = 3'(k);
      in_check = ~in_check;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || crc_out !== 3'b101 || crc_err !== EXP_BAD_ERR || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d]: out_valid=%b crc_out=%b crc_err=%b in_ready=%b want 1/101/%b/0",
                           k, out_valid, crc_out, crc_err, in_ready, EXP_BAD_ERR);
      end
    end
    in_valid  = 1'b0;
    in_check  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    out_ready = 1'b1;
    in_check  = 1'b0;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_in_shift: busy=%b out_valid=%b want 1/0", busy, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_handshake: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    checks++; if (crc_out !== 3'b000 || crc_err !== 1'b0 || ser_bit !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: crc_out=%b crc_err=%b ser_bit=%b want 000/0/0", crc_out, crc_err, ser_bit);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL midrst_no_stale_result: saw out_valid=1 or in_ready=0 after abort"); end
  endtask

  task automatic test_width1();
    w1_out_ready = 1'b1;
    w1_in_data   = 1'b1;
    w1_in_valid  = 1'b1;
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    checks++; if (w1_out_valid !== 1'b0 || w1_ser_bit !== 1'b1 || w1_busy !== 1'b1) begin
      errors++; $display("FAIL w1_shift: out_valid=%b ser_bit=%b busy=%b want 0/1/1", w1_out_valid, w1_ser_bit, w1_busy);
    end
    @(posedge clk); #1;
    checks++; if (w1_out_valid !== 1'b1 || w1_crc_out !== 3'b011) begin
      errors++; $display("FAIL w1_result: out_valid=%b crc_out=%b want 1/011", w1_out_valid, w1_crc_out);
    end
    @(posedge clk); #1;
    checks++; if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0) begin
      errors++; $display("FAIL w1_return_idle: in_ready=%b out_valid=%b want 1/0", w1_in_ready, w1_out_valid);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    in_crc       = 3'b000;
    in_check     = 1'b0;
    out_ready    = 1'b1;
    w1_in_valid  = 1'b0;
    w1_in_data   = 1'b0;
    w1_in_crc    = 3'b000;
    w1_in_check  = 1'b0;
    w1_out_ready = 1'b1;

    test_reset();
    test_gen_a5();
    test_back_to_back();
    test_check_mode();
    test_hold();
    test_reset_mid();
    test_width1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
